// File: rtl/serial_pkg.sv
// Shared definitions for the serial deserializer and its matching serializer.
// Holds the frame-FSM state encoding and the fixed start/stop bit levels.
package serial_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StParity,
        StStop,
        StHold
    } state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_deserializer.sv
// Serial-to-parallel frame receiver: start bit, WIDTH payload bits LSB first, optional
// even parity, stop bit. Good frames are held on a valid/ready output until accepted.
module serial_deserializer
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_err_q, par_err_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        par_err_d   = par_err_q;
        data_d      = data_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (ser_valid && ser_in == START_BIT) begin
                    state_d   = StData;
                    cnt_d     = '0;
                    par_err_d = 1'b0;
                end
            end
            StData: begin
                if (ser_valid) begin
                    shift_d = {ser_in, shift_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_d = PARITY_EN ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (ser_valid) begin
                    // Even parity: payload bits plus parity bit must XOR to zero.
                    par_err_d = (^shift_q) ^ ser_in;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (ser_valid) begin
                    if (ser_in == STOP_BIT && !par_err_q) begin
                        data_d  = shift_q;
                        state_d = StHold;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StIdle;
                    end
                end
            end
            StHold: begin
                // Incoming bits are dropped while a frame is pending; a start bit is flagged.
                if (ser_valid && ser_in == START_BIT) begin
                    overrun_d = 1'b1;
                end
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            par_err_q   <= par_err_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = (state_q == StHold);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench for serial_deserializer: a frame-level driver queues expected outcomes,
// and an independent monitor pops and compares them whenever the DUT reports something.
module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser_in = 1'b1;
    logic       ser_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       frame_err;
    logic       overrun;

    serial_deserializer #(
        .WIDTH    (8),
        .PARITY_EN(1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ser_in   (ser_in),
        .ser_valid(ser_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         err_exp = 0;
    int         ovr_exp = 0;
    bit         hold_ready = 1'b1;
    int         gap_mode = 0;

    logic       prev_valid = 1'b0;
    logic       prev_xfer = 1'b0;
    logic       prev_ferr = 1'b0;
    logic       prev_ovr = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] mon_exp;

    function automatic void chk(input bit ok, input string name, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endfunction

    // Monitor: chooses out_ready, then checks what the DUT presents this cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                out_ready  = 1'b0;
                prev_valid = 1'b0;
                prev_xfer  = 1'b0;
                prev_ferr  = 1'b0;
                prev_ovr   = 1'b0;
            end else begin
                out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (out_valid && prev_valid && !prev_xfer)
                    chk(out_data == prev_data, "hold_stable", out_data, prev_data);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_frame", out_data, 0);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk(out_data == mon_exp, "frame_data", out_data, mon_exp);
                    end
                end
                if (frame_err) begin
                    chk(!prev_ferr, "frame_err_width", 2, 1);
                    chk(err_exp > 0, "frame_err_expected", 1, 0);
                    chk(!out_valid, "frame_err_no_valid", out_valid, 0);
                    if (err_exp > 0) err_exp--;
                end
                if (overrun) begin
                    chk(!prev_ovr, "overrun_width", 2, 1);
                    chk(ovr_exp > 0, "overrun_expected", 1, 0);
                    if (ovr_exp > 0) ovr_exp--;
                end
                prev_valid = out_valid;
                prev_xfer  = out_valid && out_ready;
                prev_ferr  = frame_err;
                prev_ovr   = overrun;
                prev_data  = out_data;
            end
        end
    end

    task automatic send_bit(input logic b);
        int n;
        n = (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
        repeat (n) begin
            ser_valid = 1'b0;
            ser_in    = 1'($urandom);
            @(posedge clk);
            #1;
        end
        ser_valid = 1'b1;
        ser_in    = b;
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
        ser_in    = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] v, input bit par_ok, input bit stop_ok);
        if (par_ok && stop_ok) exp_q.push_back(v);
        else err_exp++;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
        send_bit((^v) ^ !par_ok);
        send_bit(stop_ok);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || err_exp != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) chk(1'b0, {"drain_timeout_", tag}, exp_q.size() + err_exp, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(out_valid, {"valid_timeout_", tag}, out_valid, 1);
    endtask

    task automatic check_zero(input string tag);
        chk(out_data == 8'h00, {tag, "_out_data"}, out_data, 0);
        chk(!out_valid, {tag, "_out_valid"}, out_valid, 0);
        chk(!frame_err, {tag, "_frame_err"}, frame_err, 0);
        chk(!overrun, {tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        logic [7:0] v;
        int         r;

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n      = 1'b1;
        hold_ready = 1'b0;

        send_frame(8'hA5, 1'b1, 1'b1);
        wait_drain("a5");

        send_frame(8'h01, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        wait_drain("bad_parity");

        hold_ready = 1'b1;
        send_frame(8'h7E, 1'b1, 1'b1);
        wait_valid("7e");
        ovr_exp++;
        send_bit(1'b0);
        repeat (18) @(posedge clk);
        #1;
        chk(out_valid, "hold_valid", out_valid, 1);
        chk(out_data == 8'h7E, "hold_data", out_data, 8'h7E);
        chk(ovr_exp == 0, "overrun_seen", ovr_exp, 0);
        hold_ready = 1'b0;
        wait_drain("7e");

        gap_mode = 1;
        send_frame(8'hFF, 1'b1, 1'b1);
        gap_mode = 0;
        wait_drain("ff");

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        #2 rst_n = 1'b0;
        #1 check_zero("reset_mid");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b1);
        wait_drain("5a");

        send_frame(8'h00, 1'b1, 1'b0);
        wait_drain("bad_stop");

        hold_ready = 1'b1;
        send_frame(8'h33, 1'b1, 1'b1);
        wait_valid("33");
        #2 rst_n = 1'b0;
        #1 check_zero("reset_hold");
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        hold_ready = 1'b0;

        for (int k = 0; k < 40; k++) begin
            v = 8'($urandom);
            r = int'($urandom_range(0, 9));
            send_frame(v, r != 0, r != 1);
            wait_drain("random");
        end

        repeat (5) @(posedge clk);
        #1;
        chk(exp_q.size() == 0, "final_frames_left", exp_q.size(), 0);
        chk(err_exp == 0, "final_err_left", err_exp, 0);
        chk(ovr_exp == 0, "final_ovr_left", ovr_exp, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
